div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Multi-cycle 32-bit radix-2 restoring divider for the EX stage. It executes DIV and DIVU operations decoded upstream in ID. EX drives operands and a start request, then stalls the pipeline until ready_o rises. The 64-bit result is {remainder, quotient}; the HI/LO write path consumes it as HI = remainder, LO = quotient.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled only at accept.
- opdata1_i  input  32  dividend. Sampled only at accept.
- opdata2_i  input  32  divisor. Sampled only at accept.
- start_i  input  1  request. Held high by EX until ready_o is seen.
- annul_i  input  1  abort the current or requested operation, e.g. on a branch flush or exception.
- result_o  output  64  {remainder[63:32], quotient[31:0]}. Valid only while ready_o = 1.
- ready_o  output  1  result valid.

Behaviour:
- Reset and clock: one clock, clk. rst is synchronous and active-high. When rst = 1 at an edge:
  - state becomes FREE;
  - result_o = 64'h0, ready_o = 0;
  - the internal counter and dividend/remainder registers are cleared.
  - This applies at any point, including mid-operation.
- FSM states: FREE, BYZERO, ON, END.
- FREE:
  - start_i = 1, annul_i = 0, opdata2_i ≠ 0 → ON. Latch the absolute values of the operands, latch the signs, set cnt = 0.
  - start_i = 1, annul_i = 0, opdata2_i = 0 → BYZERO.
  - Otherwise stay in FREE. ready_o = 0 and result_o = 0 throughout FREE.
- Absolute values:
  - Computed only when signed_div_i = 1 and the operand bit 31 is set; otherwise the raw value is used.
  - The absolute value of 32'h80000000 is 32'h80000000, treated as unsigned.
- BYZERO: on the next edge go to END with result_o = 0.
- ON (one iteration per cycle):
  - Shift the remainder left and bring in the dividend MSB.
  - Trial-subtract the divisor (DATA_W+1-bit subtract).
  - If the difference is non-negative, keep it and shift in quotient bit 1; else shift in 0.
  - cnt increments each iteration.
  - On the edge where cnt = 31 completes the final iteration, go to END and register:
    - quotient, negated if signed and sign1 ^ sign2;
    - remainder, negated if signed and the dividend was negative.
  - Results wrap modulo 2^32: 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
- END: ready_o = 1 and result_o holds steady. When start_i = 0, go to FREE next edge, clearing ready_o and result_o. While start_i stays high, remain in END; there is no re-start without a low cycle.
- annul_i:
  - In ON or BYZERO: next edge → FREE, ready_o = 0, result_o = 0, no result produced.
  - In END: treated as start_i = 0, so → FREE.
  - annul_i has priority over start_i in every state.
- Latency, with the accept edge as E0:
  - normal: ready_o high after edge E32, i.e. 32 cycles after accept;
  - divide by zero: ready_o high after edge E2.
- Operand changes: operand or signed_div_i changes after accept have no effect. start_i pulses while busy are ignored.
- Outputs are registered only, with no combinational path from any input to the outputs.

Test Plan:
1. Unsigned 100 / 7: start at E0 → ready_o rises after E32, result_o = {32'd2, 32'd14}. Drop start_i → ready_o = 0 and result_o = 0 next cycle.
2. Signed -7 / 2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Same operands with signed_div_i = 0 → quotient 0x7FFFFFFC, remainder 0x1.
3. Divide by zero: 0x1234 / 0 → ready_o after E2, result_o = 0. Then state FREE once start_i drops.
4. Edge values (signed):
   - 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0;
   - 5 / 9 → quotient 0, remainder 5.
5. Annul mid-operation: assert annul_i at iteration cnt = 10 → FREE next cycle, ready_o never rises. A new start of 50 / 5 then yields {0, 10} at full latency.
6. rst asserted at cnt = 20 → all outputs 0 next edge. Operands changed during ON in test 1 do not alter the result.

Source files
------------

// File: rtl/div_unit_if.sv
// EX <-> divider handshake: operands and start/annul in, registered {remainder, quotient} and ready out.
interface div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient},
// held in END until EX drops start_i.
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t              state_q, state_next;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   dvd_q, dsr_q, rem_q, quo_q;
  logic                neg1_q, neg2_q;
  logic                ready_q;
  logic [2*DATA_W-1:0] result_q;

  logic                neg1, neg2;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W:0]     rem_sh;
  logic                fit;
  logic [DATA_W-1:0]   rem_next, quo_next, q_final, r_final;
  logic                last;

  // Operand conditioning at accept; 0x80000000 stays as-is and is treated as unsigned.
  always_comb begin
    neg1 = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    neg2 = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    abs1 = neg1 ? -bus.opdata1_i : bus.opdata1_i;
    abs2 = neg2 ? -bus.opdata2_i : bus.opdata2_i;
  end

  always_comb begin
    rem_sh   = {rem_q, dvd_q[DATA_W-1]};
    fit      = (rem_sh >= {1'b0, dsr_q});
    rem_next = fit ? (rem_sh[DATA_W-1:0] - dsr_q) : rem_sh[DATA_W-1:0];
    quo_next = {quo_q[DATA_W-2:0], fit};
    last     = (cnt_q == CNT_W'(DATA_W - 1));
    q_final  = (neg1_q ^ neg2_q) ? -quo_next : quo_next;
    r_final  = neg1_q ? -rem_next : rem_next;
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      FREE: begin
        if (bus.start_i && !bus.annul_i)
          state_next = (bus.opdata2_i == '0) ? BYZERO : ON;
      end
      BYZERO: state_next = bus.annul_i ? FREE : END;
      ON: begin
        if (bus.annul_i)  state_next = FREE;
        else if (last)    state_next = END;
      end
      END: begin
        if (bus.annul_i || !bus.start_i) state_next = FREE;
      end
      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_next;

      if (state_q == FREE && state_next == ON) begin
        dvd_q  <= abs1;
        dsr_q  <= abs2;
        rem_q  <= '0;
        quo_q  <= '0;
        cnt_q  <= '0;
        neg1_q <= neg1;
        neg2_q <= neg2;
      end else if (state_q == ON && state_next == ON) begin
        dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
        rem_q <= rem_next;
        quo_q <= quo_next;
        cnt_q <= cnt_q + 1'b1;
      end

      // A divide-by-zero spends one cycle in END before ready rises, giving ready after
      // the second edge; the ON path raises ready on the same edge it enters END.
      if (state_next != END) begin
        ready_q  <= 1'b0;
        result_q <= '0;
      end else if (state_q == ON) begin
        ready_q  <= 1'b1;
        result_q <= {r_final, q_final};
      end else if (state_q == END) begin
        ready_q  <= 1'b1;
      end
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divisions push expected results, a negedge
// monitor pops and checks them (value and latency) whenever ready_o rises.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic        ready_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && bus.ready_o && !ready_prev) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got result %h with ready=1, required no ready", bus.result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (bus.result_o !== e.res) begin
          bad++;
          $display("FAIL result: got %h required %h", bus.result_o, e.res);
        end
        total++;
        if (cyc - e.acc != e.lat) begin
          bad++;
          $display("FAIL latency: got %0d required %0d", cyc - e.acc, e.lat);
        end
      end
    end
    ready_prev = bus.ready_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ready_o) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout: got ready=0 after 40 cycles required ready=1", name);
    end
  endtask

  // Issue one division, scramble the operands after accept, hold in END, then release.
  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int unsigned lat, input bit end_by_annul);
    exp_t e;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    tick();
    e.res = exp;
    e.acc = cyc;
    e.lat = lat;
    sb.push_back(e);
    bus.signed_div_i = ~sgn;
    bus.opdata1_i    = 32'hDEAD_BEEF;
    bus.opdata2_i    = 32'h0000_0003;
    wait_ready(name);
    tick();
    chk({name, "_hold_ready"}, {63'd0, bus.ready_o}, 64'd1);
    chk({name, "_hold_result"}, bus.result_o, exp);
    if (end_by_annul) bus.annul_i = 1'b1;
    else              bus.start_i = 1'b0;
    tick();
    chk({name, "_drop_ready"}, {63'd0, bus.ready_o}, 64'd0);
    chk({name, "_drop_result"}, bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();
  endtask

  initial begin
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    chk("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_op("u_100_7",      1'b0, 32'd100,       32'd7,          {32'd2, 32'd14},                 32, 1'b0);
    run_op("s_m7_2",       1'b1, 32'hFFFF_FFF9, 32'h2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  32, 1'b0);
    run_op("u_m7_2",       1'b0, 32'hFFFF_FFF9, 32'h2,          {32'h1, 32'h7FFF_FFFC},          32, 1'b0);
    run_op("div_zero",     1'b0, 32'h1234,      32'h0,          64'd0,                           2,  1'b0);
    run_op("s_min_m1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  {32'h0, 32'h8000_0000},          32, 1'b0);
    run_op("s_5_9",        1'b1, 32'd5,         32'd9,          {32'd5, 32'd0},                  32, 1'b0);
    run_op("s_100_m7",     1'b1, 32'd100,       32'hFFFF_FFF9,  {32'd2, 32'hFFFF_FFF2},          32, 1'b0);
    run_op("s_m100_7",     1'b1, 32'hFFFF_FF9C, 32'd7,          {32'hFFFF_FFFE, 32'hFFFF_FFF2},  32, 1'b1);
    run_op("u_max_1",      1'b0, 32'hFFFF_FFFF, 32'd1,          {32'd0, 32'hFFFF_FFFF},          32, 1'b0);
    run_op("u_max_msb",    1'b0, 32'hFFFF_FFFF, 32'h8000_0000,  {32'h7FFF_FFFF, 32'd1},          32, 1'b0);

    // Annul at cnt = 10: no result may appear afterwards.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1234;
    bus.opdata2_i    = 32'd5;
    bus.start_i      = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    bus.annul_i = 1'b1;
    tick();
    chk("annul_ready", {63'd0, bus.ready_o}, 64'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    run_op("u_50_5",       1'b0, 32'd50,        32'd5,          {32'd0, 32'd10},                 32, 1'b0);

    // Synchronous reset at cnt = 20 abandons the operation.
    bus.opdata1_i = 32'd999;
    bus.opdata2_i = 32'd4;
    bus.start_i   = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("midrst_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_op("u_1000_3",     1'b0, 32'd1000,      32'd3,          {32'd1, 32'd333},                32, 1'b0);

    for (int i = 0; i < 5; i++) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
